uart_rx_ovs: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_ovs.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_ovs.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the RX and TX paths: frame FSM states, data width,
// default oversampling ratio and the baud prescaler divide computation.
package uart_pkg;

  localparam int DATA_W  = 8;
  localparam int OVS_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Integer division truncates, so the real baud rate is slightly above nominal.
  function automatic int baud_div(input int clk_freq, input int baud, input int ovs);
    return clk_freq / (baud * ovs);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick prescaler: one-clk tick every DIV clocks, with a synchronous clear
// that restarts the phase. Also serves as the clk_bps source of the TX path.
module uart_baud_tick #(
  parameter int DIV = 325
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clr || div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  assign tick = (div_cnt == DIV_LAST) && !clr;

endmodule

// File: rtl/uart_rx_ovs.sv
// UART receiver, 16x-style oversampling with 3-sample majority vote, 8N1 framing.
// Defining UART_RX_PARITY_EN adds one even-parity bit (8E1) and the parity_err pulse.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int OVS      = OVS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_int,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              parity_err
);

  localparam int DIV   = baud_div(CLK_FREQ, BAUD, OVS);
  localparam int CNT_W = $clog2(OVS);
  localparam int IDX_W = $clog2(DATA_W);
  // Compared against cnt on the tick that steps it into OVS/2-1, OVS/2, OVS/2+1.
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(OVS / 2 - 2);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(OVS / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(OVS / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  logic              rx_p0, rx_p1, rx_p2;
  logic              fall;
  uart_state_e       state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        smp;
  logic              bit_val;
  logic              have_bit;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shift;
  logic              tick, clr, vote, vote_at, bit_end;
  logic              int_set, int_clr, valid_set, ferr_set, shift_en;
`ifdef UART_RX_PARITY_EN
  logic              par_bad;
  logic              perr_set;
`endif

  // Stage p0/p1: metastability synchroniser; p2: previous sample for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= uart_rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  assign fall = rx_p2 & ~rx_p1;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  assign vote_at = tick && (cnt == CNT_VOTE);
  assign bit_end = tick && (cnt == CNT_LAST);
  assign vote    = (smp[0] & smp[1]) | (smp[0] & rx_p1) | (smp[1] & rx_p1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      have_bit <= 1'b0;
      bit_idx  <= '0;
    end else if (clr) begin
      cnt      <= '0;
      have_bit <= 1'b0;
      bit_idx  <= '0;
    end else begin
      if (tick) cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      // The start-bit vote lands while still inside the start bit, so only
      // votes taken in DATA/PARITY may be consumed at the next bit end.
      if (bit_end) have_bit <= 1'b0;
      else if (vote_at && (state == DATA || state == PARITY)) have_bit <= 1'b1;
      if (shift_en) bit_idx <= bit_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (tick && cnt == CNT_S0) smp[0] <= rx_p1;
    if (tick && cnt == CNT_S1) smp[1] <= rx_p1;
    if (vote_at) bit_val <= vote;
    if (shift_en) shift <= {bit_val, shift[DATA_W-1:1]};
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad <= 1'b0;
    end else if (bit_end && have_bit && state == PARITY) begin
      par_bad <= ^{shift, bit_val};
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    int_set   = 1'b0;
    int_clr   = 1'b0;
    valid_set = 1'b0;
    ferr_set  = 1'b0;
    shift_en  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_set  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (fall) begin
          clr       = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (vote_at) begin
          if (!vote) begin
            int_set   = 1'b1;
            state_nxt = DATA;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (bit_end && have_bit) begin
          shift_en = 1'b1;
          if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (bit_end && have_bit) state_nxt = STOP;
`else
        state_nxt = IDLE;
`endif
      end
      STOP: begin
        // Leave at mid-stop so a start edge straight after the stop bit is seen.
        if (vote_at) begin
          int_clr   = 1'b1;
          state_nxt = IDLE;
          if (!vote) begin
            ferr_set = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad) begin
            perr_set = 1'b1;
`endif
          end else begin
            valid_set = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_int    <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= valid_set;
      frame_err <= ferr_set;
      if (valid_set) rx_data <= shift;
      if (int_set)      rx_int <= 1'b1;
      else if (int_clr) rx_int <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= perr_set;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Self-checking bench for uart_rx_ovs at 50 MHz / 115200 baud / OVS 16 (bit = 432 clk).
// Honours UART_RX_PARITY_EN when the bundle is built with it.
module tb_uart_rx_ovs;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 115200;
  localparam int OVS      = 16;
  localparam int TICK     = CLK_FREQ / (BAUD * OVS);
  localparam int BIT      = TICK * OVS;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN   = 1'b1;
`else
  localparam bit PAR_EN   = 1'b0;
`endif
  localparam int DBITS    = PAR_EN ? 9 : 8;
  localparam int FRAME    = (DBITS + 2) * BIT;
  localparam int MID_STOP = (DBITS + 1) * BIT + BIT / 2;
  localparam int LAT_LO   = MID_STOP - TICK;
  localparam int LAT_HI   = MID_STOP + 2 * TICK + 3;
  localparam int RISE_LO  = BIT / 2 - TICK;
  localparam int RISE_HI  = BIT / 2 + 2 * TICK + 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_int, rx_valid, frame_err, parity_err;

  uart_rx_ovs #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .OVS      (OVS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rx    (uart_rx),
    .rx_data    (rx_data),
    .rx_int     (rx_int),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         v_cyc[$];
  logic [7:0] v_dat[$];
  int         f_cyc[$];
  int         p_cyc[$];
  int         r_cyc[$];
  int         d_cyc[$];
  int         viol = 0;
  logic       int_q = 1'b0;
  logic       any_q = 1'b0;
  logic [7:0] last_good = 8'h00;

  // Event recorder; pulse exclusivity and spacing are tallied in viol.
  always @(negedge clk) begin
    if (rx_valid) begin
      v_cyc.push_back(cyc);
      v_dat.push_back(rx_data);
    end
    if (frame_err)  f_cyc.push_back(cyc);
    if (parity_err) p_cyc.push_back(cyc);
    if (rx_int && !int_q) r_cyc.push_back(cyc);
    if (!rx_int && int_q) d_cyc.push_back(cyc);
    if ((int'(rx_valid) + int'(frame_err) + int'(parity_err)) > 1) viol++;
    if (any_q && (rx_valid || frame_err || parity_err)) viol++;
    int_q = rx_int;
    any_q = rx_valid | frame_err | parity_err;
  end

  // 0 = good byte, 1 = framing error, 2 = parity error
  function automatic int outcome(input logic stop, input logic pflip);
    if (!stop) return 1;
    if (PAR_EN && pflip) return 2;
    return 0;
  endfunction

  function automatic logic [8:0] body(input logic [7:0] d, input logic pflip);
    return {(^d) ^ pflip, d};
  endfunction

  task automatic clear_q();
    v_cyc.delete(); v_dat.delete(); f_cyc.delete();
    p_cyc.delete(); r_cyc.delete(); d_cyc.delete();
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [8:0] b, input logic stop, output int t0);
    t0 = cyc;
    uart_rx = 1'b0;
    repeat (BIT) @(posedge clk);
    #1;
    for (int i = 0; i < DBITS; i++) begin
      uart_rx = b[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
    uart_rx = stop;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rx_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_data: got %h want 00", rx_data);
    end
    n_cmp++;
    if ({rx_int, rx_valid, frame_err, parity_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {rx_int, rx_valid, frame_err, parity_err});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(20);
  endtask

  task automatic test_frame_55();
    int t0;
    clear_q();
    send_frame(body(8'h55, 1'b0), 1'b1, t0);
    last_good = 8'h55;
    n_cmp++;
    if (v_cyc.size() != 1 || v_dat[0] !== 8'h55) begin
      n_fail++; $display("FAIL f55_valid: got %0d pulses data %h want 1 pulse data 55", v_cyc.size(), rx_data);
    end
    n_cmp++;
    if (v_cyc.size() < 1 || v_cyc[0] - t0 < LAT_LO || v_cyc[0] - t0 > LAT_HI) begin
      n_fail++; $display("FAIL f55_latency: got %0d want %0d..%0d", (v_cyc.size() > 0) ? v_cyc[0] - t0 : -1, LAT_LO, LAT_HI);
    end
    n_cmp++;
    if (r_cyc.size() != 1 || r_cyc[0] - t0 < RISE_LO || r_cyc[0] - t0 > RISE_HI) begin
      n_fail++; $display("FAIL f55_int_rise: got %0d rises at %0d want 1 at %0d..%0d", r_cyc.size(), (r_cyc.size() > 0) ? r_cyc[0] - t0 : -1, RISE_LO, RISE_HI);
    end
    n_cmp++;
    if (d_cyc.size() != 1 || v_cyc.size() != 1 || d_cyc[0] != v_cyc[0]) begin
      n_fail++; $display("FAIL f55_int_fall: got %0d falls, fall %0d valid %0d want fall at valid", d_cyc.size(), (d_cyc.size() > 0) ? d_cyc[0] : -1, (v_cyc.size() > 0) ? v_cyc[0] : -1);
    end
    n_cmp++;
    if (f_cyc.size() + p_cyc.size() != 0) begin
      n_fail++; $display("FAIL f55_errors: got %0d error pulses want 0", f_cyc.size() + p_cyc.size());
    end
  endtask

  task automatic test_glitch();
    clear_q();
    uart_rx = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    idle(BIT);
    n_cmp++;
    if (v_cyc.size() + f_cyc.size() + p_cyc.size() + r_cyc.size() != 0) begin
      n_fail++; $display("FAIL glitch_quiet: got valid %0d ferr %0d perr %0d int %0d want all 0", v_cyc.size(), f_cyc.size(), p_cyc.size(), r_cyc.size());
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    clear_q();
    send_frame(body(8'hA5, 1'b0), 1'b1, t0);
    send_frame(body(8'h3C, 1'b0), 1'b1, t1);
    last_good = 8'h3C;
    n_cmp++;
    if (v_cyc.size() != 2 || v_dat[0] !== 8'hA5 || v_dat[1] !== 8'h3C) begin
      n_fail++; $display("FAIL b2b_data: got %0d pulses last %h want A5 then 3C", v_cyc.size(), rx_data);
    end
    n_cmp++;
    if (v_cyc.size() != 2 || v_cyc[1] - v_cyc[0] < FRAME - TICK || v_cyc[1] - v_cyc[0] > FRAME + TICK) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d want %0d +-%0d", (v_cyc.size() == 2) ? v_cyc[1] - v_cyc[0] : -1, FRAME, TICK);
    end
  endtask

  task automatic test_frame_err();
    int t0;
    clear_q();
    send_frame(body(8'h12, 1'b0), 1'b1, t0);
    last_good = 8'h12;
    send_frame(body(8'h81, 1'b0), 1'b0, t0);
    idle(BIT);
    n_cmp++;
    if (f_cyc.size() != 1 || v_cyc.size() != 1) begin
      n_fail++; $display("FAIL ferr_pulses: got ferr %0d valid %0d want 1 and 1", f_cyc.size(), v_cyc.size());
    end
    n_cmp++;
    if (rx_data !== last_good || rx_int !== 1'b0) begin
      n_fail++; $display("FAIL ferr_hold: got data %h int %b want %h 0", rx_data, rx_int, last_good);
    end
    send_frame(body(8'h7E, 1'b0), 1'b1, t0);
    last_good = 8'h7E;
    n_cmp++;
    if (v_cyc.size() != 2 || rx_data !== 8'h7E) begin
      n_fail++; $display("FAIL ferr_recover: got %0d pulses data %h want 2 and 7E", v_cyc.size(), rx_data);
    end
  endtask

  task automatic test_break();
    clear_q();
    uart_rx = 1'b0;
    repeat (12 * BIT) @(posedge clk);
    #1;
    idle(BIT);
    n_cmp++;
    if (f_cyc.size() != 1 || v_cyc.size() != 0 || p_cyc.size() != 0) begin
      n_fail++; $display("FAIL break_pulses: got ferr %0d valid %0d perr %0d want 1 0 0", f_cyc.size(), v_cyc.size(), p_cyc.size());
    end
    n_cmp++;
    if (rx_data !== last_good || rx_int !== 1'b0 || d_cyc.size() != 1) begin
      n_fail++; $display("FAIL break_hold: got data %h int %b falls %0d want %h 0 1", rx_data, rx_int, d_cyc.size(), last_good);
    end
  endtask

  task automatic test_reset_mid_frame();
    int t0;
    clear_q();
    fork
      send_frame(body(8'hF0, 1'b0), 1'b1, t0);
      begin
        repeat (5 * BIT + 200) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({rx_data, rx_int, rx_valid, frame_err, parity_err} !== 12'h000) begin
          n_fail++; $display("FAIL midrst_outputs: got %h want 000", {rx_data, rx_int, rx_valid, frame_err, parity_err});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    join
    last_good = 8'h00;
    idle(BIT);
    n_cmp++;
    if (v_cyc.size() + f_cyc.size() + p_cyc.size() != 0) begin
      n_fail++; $display("FAIL midrst_discard: got %0d pulses want 0", v_cyc.size() + f_cyc.size() + p_cyc.size());
    end
    send_frame(body(8'h0F, 1'b0), 1'b1, t0);
    last_good = 8'h0F;
    n_cmp++;
    if (v_cyc.size() != 1 || v_dat[0] !== 8'h0F || v_cyc[0] - t0 < LAT_LO || v_cyc[0] - t0 > LAT_HI) begin
      n_fail++; $display("FAIL midrst_next: got %0d pulses data %h want 1 pulse 0F in window", v_cyc.size(), rx_data);
    end
  endtask

  task automatic test_parity();
    int t0;
    clear_q();
    send_frame(body(8'hC3, 1'b0), 1'b1, t0);
    last_good = 8'hC3;
    send_frame(body(8'hC3, 1'b1), 1'b1, t0);
`ifdef UART_RX_PARITY_EN
    n_cmp++;
    if (v_cyc.size() != 1 || p_cyc.size() != 1 || f_cyc.size() != 0) begin
      n_fail++; $display("FAIL parity_pulses: got valid %0d perr %0d ferr %0d want 1 1 0", v_cyc.size(), p_cyc.size(), f_cyc.size());
    end
`else
    n_cmp++;
    if (v_cyc.size() != 2 || p_cyc.size() != 0) begin
      n_fail++; $display("FAIL noparity_pulses: got valid %0d perr %0d want 2 0", v_cyc.size(), p_cyc.size());
    end
`endif
    n_cmp++;
    if (rx_data !== 8'hC3) begin
      n_fail++; $display("FAIL parity_data: got %h want C3", rx_data);
    end
  endtask

  task automatic test_random();
    int t0, kind, gap;
    logic [7:0] d;
    logic stop, pflip;
    for (int n = 0; n < 3; n++) begin
      clear_q();
      d     = 8'($urandom);
      stop  = ($urandom_range(0, 3) != 0);
      pflip = ($urandom_range(0, 2) == 0);
      send_frame(body(d, pflip), stop, t0);
      kind = outcome(stop, pflip);
      if (kind == 0) last_good = d;
      n_cmp++;
      if (v_cyc.size() != int'(kind == 0) || f_cyc.size() != int'(kind == 1) || p_cyc.size() != int'(kind == 2)) begin
        n_fail++; $display("FAIL rand%0d_kind: byte %h stop %b pflip %b got v%0d f%0d p%0d want kind %0d", n, d, stop, pflip, v_cyc.size(), f_cyc.size(), p_cyc.size(), kind);
      end
      n_cmp++;
      if (rx_data !== last_good) begin
        n_fail++; $display("FAIL rand%0d_data: got %h want %h", n, rx_data, last_good);
      end
      gap = stop ? $urandom_range(0, 200) : $urandom_range(8, 200);
      idle(gap);
    end
  endtask

  task automatic test_exclusive();
    n_cmp++;
    if (viol != 0) begin
      n_fail++; $display("FAIL pulse_exclusive: got %0d overlapping/adjacent pulses want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_frame_55();
    test_glitch();
    test_back_to_back();
    test_frame_err();
    test_break();
    test_reset_mid_frame();
    test_parity();
    test_random();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
